// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and word/half helpers for the load/store unit
package lsu_pkg;
    localparam int HALF_W = 16;
    localparam int WAIT_W = 4;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    function automatic logic [HALF_W-1:0] upper_half(input logic [2*HALF_W-1:0] w);
        return w[2*HALF_W-1:HALF_W];
    endfunction
    function automatic logic [HALF_W-1:0] lower_half(input logic [2*HALF_W-1:0] w);
        return w[HALF_W-1:0];
    endfunction
    function automatic logic [2*HALF_W-1:0] merge_halves(input logic [HALF_W-1:0] hi, input logic [HALF_W-1:0] lo);
        return {hi, lo};
    endfunction
endpackage

// File: rtl/lsu_wait_counter.sv
// lsu_wait_counter: loadable down-counter timing the read strobe window
module lsu_wait_counter import lsu_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic [WAIT_W-1:0] value,
    output logic              zero
);
    logic [WAIT_W-1:0] count;
    always_ff @(posedge clock) begin
        if (reset) count <= '0;
        else if (load) count <= value;
        else if (dec && count != '0) count <= count - 1'b1;
    end
    assign zero = count == '0;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: splits 32-bit loads/stores over two 16-bit memory half-ports,
// waits the read latency and returns the merged word; faults out-of-range addresses.
module load_store_unit #(
    parameter int DEPTH     = 32,
    parameter int READ_WAIT = 1,
    parameter int HALF_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_address,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              stall,
    output logic              memoryWrite1,
    output logic              memoryWrite2,
    output logic              memoryRead1,
    output logic              memoryRead2,
    output logic [31:0]       address1,
    output logic [31:0]       address2,
    output logic [HALF_W-1:0] writeData1,
    output logic [HALF_W-1:0] writeData2,
    input  logic [HALF_W-1:0] readData1,
    input  logic [HALF_W-1:0] readData2
);
    import lsu_pkg::*;
    state_t state;
    logic   in_range, wait_zero, wait_load, wait_dec;
    assign in_range  = req_address < 32'(DEPTH);
    assign req_ready = state == IDLE;
    assign stall     = (req_valid && !req_ready) || (resp_valid && !resp_ready);
    assign wait_load = state == IDLE && req_valid && in_range && !req_write;
    assign wait_dec  = state == ACCESS && memoryRead1 && !wait_zero;
    lsu_wait_counter u_wait (
        .clock(clock),
        .reset(reset),
        .load (wait_load),
        .dec  (wait_dec),
        .value(WAIT_W'(READ_WAIT)),
        .zero (wait_zero)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_fault   <= 1'b0;
            memoryWrite1 <= 1'b0;
            memoryWrite2 <= 1'b0;
            memoryRead1  <= 1'b0;
            memoryRead2  <= 1'b0;
            address1     <= '0;
            address2     <= '0;
            writeData1   <= '0;
            writeData2   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    address1   <= req_address;
                    address2   <= req_address;
                    writeData1 <= upper_half(req_wdata);
                    writeData2 <= lower_half(req_wdata);
                    if (in_range) begin
                        state        <= ACCESS;
                        memoryWrite1 <= req_write;
                        memoryWrite2 <= req_write;
                        memoryRead1  <= !req_write;
                        memoryRead2  <= !req_write;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ACCESS: if (memoryWrite1) begin
                    memoryWrite1 <= 1'b0;
                    memoryWrite2 <= 1'b0;
                    resp_rdata   <= '0;
                    resp_fault   <= 1'b0;
                    resp_valid   <= 1'b1;
                    state        <= RESP;
                end else if (wait_zero) begin
                    memoryRead1 <= 1'b0;
                    memoryRead2 <= 1'b0;
                    resp_rdata  <= merge_halves(readData1, readData2);
                    resp_fault  <= 1'b0;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench with a two-half memory model
module tb_load_store_unit;
    localparam int RW = 1;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_address = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault, stall;
    logic [31:0] resp_rdata, address1, address2;
    logic        memoryWrite1, memoryWrite2, memoryRead1, memoryRead2;
    logic [15:0] writeData1, writeData2, readData1, readData2;
    logic [15:0] mem1 [32];
    logic [15:0] mem2 [32];
    logic [32:0] sb [$];
    int compared = 0, mismatched = 0;

    load_store_unit #(.DEPTH(32), .READ_WAIT(RW), .HALF_W(16)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .stall(stall), .memoryWrite1(memoryWrite1),
        .memoryWrite2(memoryWrite2), .memoryRead1(memoryRead1), .memoryRead2(memoryRead2),
        .address1(address1), .address2(address2), .writeData1(writeData1),
        .writeData2(writeData2), .readData1(readData1), .readData2(readData2)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (memoryWrite1 && address1 < 32) mem1[address1[4:0]] <= writeData1;
        if (memoryWrite2 && address2 < 32) mem2[address2[4:0]] <= writeData2;
    end
    assign readData1 = address1 < 32 ? mem1[address1[4:0]] : 16'h0;
    assign readData2 = address2 < 32 ? mem2[address2[4:0]] : 16'h0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input bit push, input logic [31:0] exp_rd, input logic exp_f);
        req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = data;
        if (push) sb.push_back({exp_f, exp_rd});
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the cycle after acceptance; measures latency and strobe activity, then drains one response.
    task automatic wait_resp(input string tag, input int exp_lat, input int exp_rd, input int exp_wr, input int hold);
        int cyc = 1, rd = 0, wr = 0, bad = 0;
        logic [32:0] exp;
        logic [31:0] first;
        resp_ready = hold == 0;
        while (!resp_valid && cyc < 20) begin
            rd += int'(memoryRead1);
            wr += int'(memoryWrite1);
            if (((memoryRead1 | memoryRead2) & (memoryWrite1 | memoryWrite2)) ||
                memoryRead1 != memoryRead2 || memoryWrite1 != memoryWrite2) bad++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " read cycles"}, rd, exp_rd);
        check({tag, " write cycles"}, wr, exp_wr);
        check({tag, " strobe pairing"}, bad, 0);
        first = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " held valid"}, resp_valid, 1);
            check({tag, " held rdata"}, resp_rdata, first);
            check({tag, " stall"}, stall, 1);
            check({tag, " not ready"}, req_ready, 0);
            check({tag, " no strobe"}, {memoryWrite1, memoryRead1}, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        check({tag, " stall released"}, stall, 0);
        if (sb.size() == 0) check({tag, " scoreboard empty"}, 1, 0);
        else begin
            exp = sb.pop_front();
            check({tag, " rdata"}, resp_rdata, exp[31:0]);
            check({tag, " fault"}, resp_fault, exp[32]);
        end
        tick();
        check({tag, " valid cleared"}, resp_valid, 0);
        check({tag, " ready again"}, req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mem1[i] = '0; mem2[i] = '0; end
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'd3; req_wdata = 32'h1111_2222;
        tick(); tick();
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset rdata", resp_rdata, 0);
        check("reset fault", resp_fault, 0);
        check("reset strobes", {memoryWrite1, memoryWrite2, memoryRead1, memoryRead2}, 0);
        check("reset address", address1 | address2, 0);
        check("reset wdata", {writeData1, writeData2}, 0);
        req_valid = 1'b0;
        reset = 1'b0;
        tick();

        issue(1'b1, 32'd5, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        check("store addr", address1, 5);
        check("store addr2", address2, 5);
        check("store wd1", writeData1, 32'hDEAD);
        check("store wd2", writeData2, 32'hBEEF);
        wait_resp("store5", 2, 0, 1, 0);
        check("mem5", {mem1[5], mem2[5]}, 32'hDEAD_BEEF);

        issue(1'b0, 32'd5, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        wait_resp("load5", 2 + RW, RW + 1, 0, 0);

        issue(1'b0, 32'd32, 32'h0, 1, 32'h0, 1'b1);
        wait_resp("fault32", 1, 0, 0, 0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0, 1, 32'h0, 1'b1);
        wait_resp("faultmax", 1, 0, 0, 0);
        issue(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 32'h0, 1'b1);
        wait_resp("faultstore", 1, 0, 0, 0);

        issue(1'b1, 32'd31, 32'h1234_5678, 1, 32'h0, 1'b0);
        wait_resp("store31", 2, 0, 1, 0);
        check("mem31", {mem1[31], mem2[31]}, 32'h1234_5678);
        issue(1'b1, 32'd0, 32'hA5A5_0F0F, 1, 32'h0, 1'b0);
        wait_resp("store0", 2, 0, 1, 0);

        issue(1'b0, 32'd31, 32'h0, 1, 32'h1234_5678, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'd6; req_wdata = 32'hAAAA_5555;
        wait_resp("hold31", 2 + RW, RW + 1, 0, 4);
        check("mem6 untouched", {mem1[6], mem2[6]}, 0);
        issue(1'b0, 32'd0, 32'h0, 1, 32'hA5A5_0F0F, 1'b0);
        wait_resp("load0", 2 + RW, RW + 1, 0, 0);

        issue(1'b0, 32'd5, 32'h0, 0, 32'h0, 1'b0);
        check("abort read strobe", {memoryRead1, memoryRead2}, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort strobes", {memoryWrite1, memoryWrite2, memoryRead1, memoryRead2}, 0);
        check("abort valid", resp_valid, 0);
        check("abort ready", req_ready, 1);
        tick(); tick(); tick();
        check("abort no response", resp_valid, 0);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
